// File: rtl/ecp5_pll_phase_ctl_if.sv
// Command channel between a phase-adjust requester and ecp5_pll_phase_ctl.
// A command transfers on a rising clk edge where cmd_valid && cmd_ready; the
// requester holds cmd_chan/cmd_dir/cmd_count stable while cmd_valid waits.
interface ecp5_pll_phase_ctl_if #(
  parameter int STEPW = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_chan;
  logic             cmd_dir;
  logic [STEPW-1:0] cmd_count;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_chan, cmd_dir, cmd_count,
    input  cmd_ready, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_chan, cmd_dir, cmd_count,
    output cmd_ready, busy, done, err
  );
endinterface

// File: rtl/ecp5_pll_phase_ctl.sv
// ECP5 EHXPLLL dynamic phase stepper with LOCK filtering and a downstream
// reset generator; runs on the PLL reference clock.
module ecp5_pll_phase_ctl #(
  parameter int NCHAN     = 4,
  parameter int STEPW     = 8,
  parameter int SETUP     = 4,
  parameter int PULSE     = 4,
  parameter int RECOV     = 8,
  parameter int LOCK_FILT = 16,
  parameter int RST_HOLD  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pll_lock,
  ecp5_pll_phase_ctl_if.slave  cmd,
  output logic [1:0]           phasesel,
  output logic                 phasedir,
  output logic                 phasestep,
  output logic                 lock_ok,
  output logic                 rst_out,
  output logic [2:0]           state_dbg
);
  localparam int LW   = $clog2(LOCK_FILT + 1);
  localparam int HW   = $clog2(RST_HOLD + 1);
  localparam int WMAX = (SETUP > PULSE) ? ((SETUP > RECOV) ? SETUP : RECOV)
                                        : ((PULSE > RECOV) ? PULSE : RECOV);
  localparam int WW   = $clog2(WMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOW   = 3'd2,
    S_RECOV = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             sync1, lock_s;
  logic [LW-1:0]    lcnt, lcnt_nxt;
  logic             lock_ok_nxt;
  logic [HW-1:0]    hcnt;
  logic [WW-1:0]    wcnt, wcnt_nxt;
  logic [STEPW-1:0] remaining, rem_nxt;
  logic             abort_q, abort_nxt, fail_q, fail_nxt;
  logic             accept;
  logic             ready_q, ready_nxt, busy_q, busy_nxt, done_q, done_nxt, err_q, err_nxt;
  logic             step_nxt, dir_nxt;
  logic [1:0]       sel_nxt;

  // Lock filter: lock_ok tracks the registered counter reaching LOCK_FILT
  always_comb begin
    lcnt_nxt = lcnt;
    if (!lock_s)
      lcnt_nxt = '0;
    else if (lcnt != LW'(LOCK_FILT))
      lcnt_nxt = lcnt + 1'b1;
  end

  assign lock_ok_nxt = (lcnt_nxt == LW'(LOCK_FILT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      lock_s  <= 1'b0;
      lcnt    <= '0;
      lock_ok <= 1'b0;
      hcnt    <= '0;
      rst_out <= 1'b1;
    end else begin
      sync1   <= pll_lock;
      lock_s  <= sync1;
      lcnt    <= lcnt_nxt;
      lock_ok <= lock_ok_nxt;
      if (!lock_ok_nxt) begin
        hcnt    <= '0;
        rst_out <= 1'b1;
      end else if (hcnt != HW'(RST_HOLD)) begin
        hcnt <= hcnt + 1'b1;
      end else begin
        rst_out <= 1'b0;
      end
    end
  end

  assign accept = cmd.cmd_valid && ready_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state; a lock loss inside LOW is remembered so the pulse is never cut short
  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    abort_nxt = abort_q;
    fail_nxt  = fail_q;
    unique case (state)
      S_IDLE: begin
        abort_nxt = 1'b0;
        fail_nxt  = 1'b0;
        if (accept) begin
          rem_nxt = cmd.cmd_count;
          if (int'(cmd.cmd_chan) >= NCHAN) begin
            fail_nxt  = 1'b1;
            state_nxt = S_FIN;
          end else if (cmd.cmd_count == '0) begin
            state_nxt = S_FIN;
          end else begin
            state_nxt = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (!lock_ok) begin
          fail_nxt  = 1'b1;
          state_nxt = S_FIN;
        end else if (wcnt == WW'(SETUP - 1)) begin
          state_nxt = S_LOW;
        end
      end
      S_LOW: begin
        if (!lock_ok) abort_nxt = 1'b1;
        if (wcnt == WW'(PULSE - 1)) begin
          rem_nxt = remaining - 1'b1;
          if (abort_nxt) begin
            fail_nxt  = 1'b1;
            state_nxt = S_FIN;
          end else begin
            state_nxt = S_RECOV;
          end
        end
      end
      S_RECOV: begin
        if (!lock_ok) begin
          fail_nxt  = 1'b1;
          state_nxt = S_FIN;
        end else if (wcnt == WW'(RECOV - 1)) begin
          state_nxt = (remaining == '0) ? S_FIN : S_LOW;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    wcnt_nxt = (state_nxt != state || state == S_IDLE) ? '0 : wcnt + 1'b1;
  end

  // Outputs are registered from the next state so they align with it
  always_comb begin
    ready_nxt = (state_nxt == S_IDLE) && lock_ok_nxt;
    step_nxt  = (state_nxt != S_LOW);
    busy_nxt  = (state_nxt != S_IDLE);
    done_nxt  = (state_nxt == S_FIN);
    err_nxt   = (state_nxt == S_FIN) && fail_nxt;
    sel_nxt   = phasesel;
    dir_nxt   = phasedir;
    if (state == S_IDLE && state_nxt == S_SETUP) begin
      sel_nxt = cmd.cmd_chan;
      dir_nxt = cmd.cmd_dir;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt      <= '0;
      remaining <= '0;
      abort_q   <= 1'b0;
      fail_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      phasestep <= 1'b1;
      phasesel  <= 2'd0;
      phasedir  <= 1'b0;
    end else begin
      wcnt      <= wcnt_nxt;
      remaining <= rem_nxt;
      abort_q   <= abort_nxt;
      fail_q    <= fail_nxt;
      ready_q   <= ready_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
      phasestep <= step_nxt;
      phasesel  <= sel_nxt;
      phasedir  <= dir_nxt;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign cmd.busy      = busy_q;
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;
  assign state_dbg     = state;
endmodule

// File: tb/tb_ecp5_pll_phase_ctl.sv
// Bench for ecp5_pll_phase_ctl: command timelines and lock/reset behaviour are
// predicted from arithmetic on the configured timing and a sampled-lock history.
module tb_ecp5_pll_phase_ctl;
  localparam int NCHAN     = 2;
  localparam int STEPW     = 8;
  localparam int SETUP     = 4;
  localparam int PULSE     = 4;
  localparam int RECOV     = 8;
  localparam int LOCK_FILT = 16;
  localparam int RST_HOLD  = 32;

  logic       clk, reset, pll_lock;
  logic [1:0] phasesel;
  logic       phasedir, phasestep, lock_ok, rst_out;
  logic [2:0] state_dbg;

  ecp5_pll_phase_ctl_if #(.STEPW(STEPW)) cmd_if ();

  ecp5_pll_phase_ctl #(
    .NCHAN(NCHAN), .STEPW(STEPW), .SETUP(SETUP), .PULSE(PULSE),
    .RECOV(RECOV), .LOCK_FILT(LOCK_FILT), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .cmd(cmd_if),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .lock_ok(lock_ok), .rst_out(rst_out), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Lock reference: a raw LOCK sample reaches the filter two edges later;
  // lock_ok needs LOCK_FILT consecutive high samples, rst_out drops RST_HOLD edges after.
  logic [1:0] raw_hist;
  int         run_len, hold_len;
  logic       m_lock_ok, m_rst;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_hist  = 2'b00;
      run_len   = 0;
      hold_len  = 0;
      m_lock_ok = 1'b0;
      m_rst     = 1'b1;
    end else begin
      run_len  = raw_hist[1] ? run_len + 1 : 0;
      raw_hist = {raw_hist[0], pll_lock};
      if (run_len >= LOCK_FILT) begin
        hold_len  = m_lock_ok ? hold_len + 1 : 0;
        m_lock_ok = 1'b1;
      end else begin
        hold_len  = 0;
        m_lock_ok = 1'b0;
      end
      m_rst = !m_lock_ok || (hold_len < RST_HOLD);
    end
  end

  // Scoreboard state filled by the driver/monitor
  logic [15:0] exp_q[$];
  logic [15:0] fall_q[$];
  logic [15:0] width_q[$];
  int          obs_done_k, obs_wait, obs_sel_bad, obs_lock_bad, obs_busy_bad;
  logic        obs_err;
  logic [1:0]  last_sel;
  logic        last_dir;

  function automatic int exp_done_k(input int n);
    return SETUP + n * (PULSE + RECOV);
  endfunction

  // Driver/monitor: k counts negedges after the accepting edge
  task automatic do_cmd(input logic [1:0] ch, input logic d, input logic [7:0] n,
                        input int glitch_k, input logic hold,
                        input logic [1:0] nch, input logic nd, input logic [7:0] nn);
    int   w, low_len;
    logic prev_ps;
    fall_q.delete();
    width_q.delete();
    obs_done_k = -1; obs_err = 1'b0; obs_sel_bad = 0; obs_lock_bad = 0; obs_busy_bad = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_chan  = ch;
    cmd_if.cmd_dir   = d;
    cmd_if.cmd_count = n;
    w = 0;
    while (cmd_if.cmd_ready !== 1'b1 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    obs_wait = w;
    if (cmd_if.cmd_ready !== 1'b1) begin
      obs_done_k = -2;
      cmd_if.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      cmd_if.cmd_chan  = nch;
      cmd_if.cmd_dir   = nd;
      cmd_if.cmd_count = nn;
    end else begin
      cmd_if.cmd_valid = 1'b0;
    end
    prev_ps = 1'b1;
    low_len = 0;
    for (int k = 0; k < 5000; k++) begin
      if (k > 0) @(negedge clk);
      if (k == glitch_k) pll_lock = 1'b0;
      else if (k == glitch_k + 1) pll_lock = 1'b1;
      if (lock_ok !== m_lock_ok || rst_out !== m_rst) obs_lock_bad++;
      if (phasestep === 1'b0) begin
        if (prev_ps) begin
          fall_q.push_back(16'(k));
          low_len = 0;
        end
        low_len++;
        if (phasesel !== ch || phasedir !== d) obs_sel_bad++;
      end else if (prev_ps === 1'b0) begin
        width_q.push_back(16'(low_len));
      end
      prev_ps = phasestep;
      if (cmd_if.done === 1'b1) begin
        obs_done_k = k;
        obs_err    = cmd_if.err;
        break;
      end
      if (cmd_if.busy !== 1'b1) obs_busy_bad++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cmd_if.cmd_ready, phasesel, phasedir, phasestep, cmd_if.busy, cmd_if.done,
         cmd_if.err, lock_ok, rst_out} !== 10'b0000100001) begin
      n_bad++;
      $display("FAIL reset_values: got %b expected %b",
               {cmd_if.cmd_ready, phasesel, phasedir, phasestep, cmd_if.busy, cmd_if.done,
                cmd_if.err, lock_ok, rst_out}, 10'b0000100001);
    end
    reset = 1'b0;
  endtask

  task automatic test_power_up;
    int rise_t, fall_t, bad;
    rise_t = -1; fall_t = -1; bad = 0;
    repeat (4) @(negedge clk);
    pll_lock = 1'b1;
    for (int t = 1; t <= LOCK_FILT + RST_HOLD + 10; t++) begin
      @(negedge clk);
      if (lock_ok !== m_lock_ok || rst_out !== m_rst || cmd_if.cmd_ready !== m_lock_ok) bad++;
      if (rise_t < 0 && lock_ok === 1'b1) rise_t = t;
      if (fall_t < 0 && rst_out === 1'b0) fall_t = t;
    end
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL powerup_track: got %0d bad cycles expected 0", bad); end
    n_cmp++;
    if (rise_t !== LOCK_FILT + 2) begin
      n_bad++; $display("FAIL lock_ok_rise: got %0d expected %0d", rise_t, LOCK_FILT + 2);
    end
    n_cmp++;
    if (fall_t !== LOCK_FILT + 2 + RST_HOLD) begin
      n_bad++; $display("FAIL rst_out_fall: got %0d expected %0d", fall_t, LOCK_FILT + 2 + RST_HOLD);
    end
  endtask

  // Fixed command from the plan first, then random channel/direction/count
  task automatic test_steps;
    logic [1:0] ch;
    logic       d;
    logic [7:0] n;
    int         bad_w;
    for (int r = 0; r < 7; r++) begin
      if (r == 0) begin ch = 2'd1; d = 1'b1; n = 8'd3; end
      else begin
        ch = 2'($urandom_range(0, NCHAN - 1));
        d  = 1'($urandom_range(0, 1));
        n  = 8'($urandom_range(1, 6));
      end
      do_cmd(ch, d, n, -10, 1'b0, 2'd0, 1'b0, 8'd0);
      last_sel = ch; last_dir = d;
      exp_q.delete();
      for (int i = 0; i < int'(n); i++) exp_q.push_back(16'(SETUP + i * (PULSE + RECOV)));
      n_cmp++;
      if (obs_done_k !== exp_done_k(int'(n))) begin
        n_bad++; $display("FAIL step_done_time: got %0d expected %0d", obs_done_k, exp_done_k(int'(n)));
      end
      n_cmp++;
      if (obs_err !== 1'b0) begin n_bad++; $display("FAIL step_err: got %b expected 0", obs_err); end
      n_cmp++;
      if (fall_q.size() !== exp_q.size()) begin
        n_bad++; $display("FAIL step_pulses: got %0d expected %0d", fall_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_cmp++;
          if (fall_q[i] !== exp_q[i]) begin
            n_bad++; $display("FAIL step_fall_pos: got %0d expected %0d", fall_q[i], exp_q[i]);
          end
        end
      end
      bad_w = 0;
      foreach (width_q[i]) if (width_q[i] !== 16'(PULSE)) bad_w++;
      n_cmp++;
      if (bad_w !== 0 || width_q.size() !== int'(n)) begin
        n_bad++; $display("FAIL step_width: got %0d bad of %0d expected 0 of %0d", bad_w, width_q.size(), n);
      end
      n_cmp++;
      if (obs_sel_bad + obs_busy_bad + obs_lock_bad !== 0) begin
        n_bad++; $display("FAIL step_stability: got sel %0d busy %0d lock %0d expected 0",
                          obs_sel_bad, obs_busy_bad, obs_lock_bad);
      end
      n_cmp++;
      if (phasesel !== ch || phasedir !== d) begin
        n_bad++; $display("FAIL step_sel_hold: got %0d/%b expected %0d/%b", phasesel, phasedir, ch, d);
      end
    end
  endtask

  // Zero count, out-of-range channels and the largest count
  task automatic test_boundary;
    logic [1:0] bad_ch[2];
    bad_ch[0] = 2'd3;
    bad_ch[1] = 2'(NCHAN);
    do_cmd(2'd0, ~last_dir, 8'd0, -10, 1'b0, 2'd0, 1'b0, 8'd0);
    n_cmp++;
    if (obs_done_k !== 0 || obs_err !== 1'b0 || fall_q.size() !== 0) begin
      n_bad++; $display("FAIL zero_count: got done_k %0d err %b pulses %0d expected 0 0 0",
                        obs_done_k, obs_err, fall_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      do_cmd(bad_ch[i], ~last_dir, 8'd5, -10, 1'b0, 2'd0, 1'b0, 8'd0);
      n_cmp++;
      if (obs_done_k !== 0 || obs_err !== 1'b1 || fall_q.size() !== 0) begin
        n_bad++; $display("FAIL bad_chan: got done_k %0d err %b pulses %0d expected 0 1 0",
                          obs_done_k, obs_err, fall_q.size());
      end
    end
    n_cmp++;
    if (phasesel !== last_sel || phasedir !== last_dir) begin
      n_bad++; $display("FAIL reject_keeps_sel: got %0d/%b expected %0d/%b", phasesel, phasedir, last_sel, last_dir);
    end
    do_cmd(2'd0, 1'b0, 8'd255, -10, 1'b0, 2'd0, 1'b0, 8'd0);
    last_sel = 2'd0; last_dir = 1'b0;
    n_cmp++;
    if (fall_q.size() !== 255) begin
      n_bad++; $display("FAIL max_count_pulses: got %0d expected 255", fall_q.size());
    end
    n_cmp++;
    if (obs_done_k !== exp_done_k(255) || obs_err !== 1'b0) begin
      n_bad++; $display("FAIL max_count_done: got %0d err %b expected %0d err 0", obs_done_k, obs_err, exp_done_k(255));
    end
  endtask

  // One-cycle LOCK drop while the second pulse is low
  task automatic test_lock_glitch;
    int bad, bad_w;
    do_cmd(2'd1, 1'b0, 8'd5, SETUP + PULSE + RECOV, 1'b0, 2'd0, 1'b0, 8'd0);
    last_sel = 2'd1; last_dir = 1'b0;
    bad_w = 0;
    foreach (width_q[i]) if (width_q[i] !== 16'(PULSE)) bad_w++;
    n_cmp++;
    if (fall_q.size() !== 2 || width_q.size() !== 2 || bad_w !== 0) begin
      n_bad++; $display("FAIL glitch_pulses: got %0d falls %0d widths %0d bad expected 2 2 0",
                        fall_q.size(), width_q.size(), bad_w);
    end
    n_cmp++;
    if (obs_done_k !== SETUP + PULSE + RECOV + PULSE || obs_err !== 1'b1) begin
      n_bad++; $display("FAIL glitch_done: got %0d err %b expected %0d err 1",
                        obs_done_k, obs_err, SETUP + PULSE + RECOV + PULSE);
    end
    n_cmp++;
    if (rst_out !== 1'b1 || obs_lock_bad !== 0) begin
      n_bad++; $display("FAIL glitch_rst: got rst_out %b lock_bad %0d expected 1 0", rst_out, obs_lock_bad);
    end
    bad = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (lock_ok !== m_lock_ok || rst_out !== m_rst) bad++;
      if (m_rst === 1'b0 && rst_out === 1'b0) break;
    end
    n_cmp++;
    if (bad !== 0 || rst_out !== 1'b0) begin
      n_bad++; $display("FAIL relock_hold: got %0d bad cycles rst_out %b expected 0 0", bad, rst_out);
    end
  endtask

  task automatic test_back_to_back;
    do_cmd(2'd0, 1'b1, 8'd2, -10, 1'b1, 2'd1, 1'b0, 8'd1);
    n_cmp++;
    if (obs_done_k !== exp_done_k(2) || obs_err !== 1'b0 || fall_q.size() !== 2 || obs_sel_bad !== 0) begin
      n_bad++; $display("FAIL b2b_first: got done_k %0d err %b pulses %0d sel_bad %0d expected %0d 0 2 0",
                        obs_done_k, obs_err, fall_q.size(), obs_sel_bad, exp_done_k(2));
    end
    do_cmd(2'd1, 1'b0, 8'd1, -10, 1'b0, 2'd0, 1'b0, 8'd0);
    n_cmp++;
    if (obs_wait !== 1) begin
      n_bad++; $display("FAIL b2b_accept_gap: got %0d expected 1", obs_wait);
    end
    n_cmp++;
    if (obs_done_k !== exp_done_k(1) || fall_q.size() !== 1 || obs_sel_bad !== 0) begin
      n_bad++; $display("FAIL b2b_second: got done_k %0d pulses %0d sel_bad %0d expected %0d 1 0",
                        obs_done_k, fall_q.size(), obs_sel_bad, exp_done_k(1));
    end
  endtask

  task automatic test_reset_mid_pulse;
    int w;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_chan  = 2'd1;
    cmd_if.cmd_dir   = 1'b1;
    cmd_if.cmd_count = 8'd4;
    w = 0;
    while (phasestep !== 1'b0 && w < 500) begin
      @(negedge clk);
      if (cmd_if.busy === 1'b1) cmd_if.cmd_valid = 1'b0;
      w++;
    end
    cmd_if.cmd_valid = 1'b0;
    n_cmp++;
    if (phasestep !== 1'b0) begin n_bad++; $display("FAIL mid_pulse_reach: got %b expected 0", phasestep); end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({phasestep, cmd_if.busy, rst_out, cmd_if.done, lock_ok, phasesel} !== 7'b1010000) begin
      n_bad++; $display("FAIL async_reset: got %b expected %b",
                        {phasestep, cmd_if.busy, rst_out, cmd_if.done, lock_ok, phasesel}, 7'b1010000);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    pll_lock         = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_chan  = 2'd0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_count = '0;
    last_sel         = 2'd0;
    last_dir         = 1'b0;
    test_reset();
    test_power_up();
    test_steps();
    test_boundary();
    test_lock_glitch();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
